// File: rtl/if_prefetch_pkg.sv
// Shared fetch-path constants, the queue entry layout and PC helpers
// for the if_prefetch front end.
package if_prefetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          DEPTH_DEF    = 4;
   localparam int          INST_W       = 32;
   localparam logic [31:0] PC_STEP      = 32'd4;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [31:0]       pc;
   } fetch_entry_t;

   // Fetch targets are always word aligned; the low two bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Bundles the ROM read port, the redirect inputs and the F/D handshake of
// the fetch front end; master is the prefetcher, slave is its environment.
interface if_prefetch_if
   import if_prefetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              imem_req;
   logic [31:0]       imem_addr;
   logic [31:0]       imem_rdata;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              fd_valid;
   logic              fd_ready;
   logic [INST_W-1:0] fd_inst;
   logic [31:0]       fd_pc;
   logic [31:0]       fd_pcplus4;
   logic [CNT_W-1:0]  fd_count;

   modport master (
      output imem_req, imem_addr, fd_valid, fd_inst, fd_pc, fd_pcplus4, fd_count,
      input  imem_rdata, redirect, redirect_pc, fd_ready
   );

   modport slave (
      input  imem_req, imem_addr, fd_valid, fd_inst, fd_pc, fd_pcplus4, fd_count,
      output imem_rdata, redirect, redirect_pc, fd_ready
   );

endinterface

// File: rtl/if_prefetch_inst_fifo.sv
// Synchronous instruction/PC queue: simultaneous push and pop are allowed,
// flush clears everything and wins over a push in the same cycle.
module if_prefetch_inst_fifo
   import if_prefetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A push into a full queue is only legal when the head leaves in the same cycle.
   always_comb begin
      do_pop  = pop & (count != {CW{1'b0}});
      do_push = push & ((count != FULL) | do_pop);
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clock) begin
      if (!reset || flush) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {CW{1'b0}};
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are don't-care until the matching pointer says otherwise.
   always_ff @(posedge clock) begin
      if (reset && !flush && do_push) mem[wr_ptr] <= push_entry;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one-word ROM reads
// under a credit limit and queues returned words with their PCs for decode.
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = DEPTH_DEF
) (
   input  logic          clock,
   input  logic          reset,
   if_prefetch_if.master bus
);

   localparam int              CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0]  DEPTH_V = (CNT_W + 1)'(DEPTH);

   logic [31:0]      fpc;
   logic [31:0]      req_pc;
   logic             pending;
   logic             issue;
   logic             head_valid;
   logic [CNT_W:0]   used;
   logic [CNT_W-1:0] count;
   fetch_entry_t     head;
   fetch_entry_t     ret_entry;

   // Credit counts the queue plus the read in flight, ignoring a same-cycle pop.
   always_comb begin
      used       = {1'b0, count} + {{CNT_W{1'b0}}, pending};
      issue      = reset & ~bus.redirect & (used < DEPTH_V);
      head_valid = reset & (count != {CNT_W{1'b0}});
      ret_entry  = '{inst: bus.imem_rdata, pc: req_pc};
   end

   // Fetch PC and in-flight tracking; a redirect drops the read in flight.
   always_ff @(posedge clock) begin
      if (!reset) begin
         fpc     <= RESET_PC;
         req_pc  <= 32'h0000_0000;
         pending <= 1'b0;
      end else if (bus.redirect) begin
         fpc     <= word_align(bus.redirect_pc);
         pending <= 1'b0;
      end else begin
         pending <= issue;
         if (issue) begin
            fpc    <= fpc + PC_STEP;
            req_pc <= fpc;
         end
      end
   end

   if_prefetch_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .flush      (bus.redirect),
      .push       (pending),
      .push_entry (ret_entry),
      .pop        (head_valid & bus.fd_ready),
      .head       (head),
      .count      (count)
   );

   // Decode-facing view; everything reads as zero while held in reset or empty.
   always_comb begin
      bus.imem_req  = issue;
      bus.imem_addr = fpc;
      bus.fd_valid  = head_valid;
      bus.fd_count  = reset ? count : {CNT_W{1'b0}};
      if (head_valid) begin
         bus.fd_inst    = head.inst;
         bus.fd_pc      = head.pc;
         bus.fd_pcplus4 = head.pc + PC_STEP;
      end else begin
         bus.fd_inst    = {INST_W{1'b0}};
         bus.fd_pc      = 32'h0000_0000;
         bus.fd_pcplus4 = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: directed phases plus random traffic
// compared every cycle against a queue-based reference of the fetch rules.
module tb_if_prefetch;
   import if_prefetch_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] PC0   = 32'h0000_0000;
   localparam logic [31:0] PC1   = 32'hFFFF_FFF8;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   if_prefetch_if #(.DEPTH(DEPTH)) bus0 ();
   if_prefetch_if #(.DEPTH(DEPTH)) bus1 ();

   if_prefetch #(.RESET_PC(PC0), .DEPTH(DEPTH)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
   if_prefetch #(.RESET_PC(PC1), .DEPTH(DEPTH)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));

   always #5 clock = ~clock;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return {2'b00, a[31:2]};
   endfunction

   // ROM models: data one cycle after a sampled request, junk otherwise.
   always @(posedge clock) begin
      bus0.imem_rdata <= bus0.imem_req ? rom(bus0.imem_addr) : 32'hDEAD_BEEF;
      bus1.imem_rdata <= bus1.imem_req ? rom(bus1.imem_addr) : 32'hDEAD_BEEF;
   end

   // Reference state: fetch pointer, the one outstanding read, the visible queue.
   logic [31:0] m_fpc;
   int          m_pend;
   logic [31:0] m_pend_pc;
   logic [31:0] m_q[$];

   logic        cur_rst, cur_redir, cur_ready;
   logic [31:0] cur_rpc;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      int occ;
      bit iss;
      if (!cur_rst) begin
         m_fpc  = PC0;
         m_q.delete();
         m_pend = 0;
      end else begin
         occ = m_q.size() + m_pend;
         iss = !cur_redir && (occ < DEPTH);
         if (m_q.size() > 0 && cur_ready) void'(m_q.pop_front());
         if (cur_redir) begin
            m_q.delete();
            m_pend = 0;
            m_fpc  = cur_rpc & ~32'd3;
         end else begin
            if (m_pend != 0) m_q.push_back(m_pend_pc);
            m_pend = iss ? 1 : 0;
            if (iss) begin
               m_pend_pc = m_fpc;
               m_fpc     = m_fpc + 32'd4;
            end
         end
      end
   endtask

   task automatic compare_dut0();
      bit          exp_req;
      bit          exp_val;
      logic [31:0] pc;
      exp_req = cur_rst && !cur_redir && ((m_q.size() + m_pend) < DEPTH);
      exp_val = cur_rst && (m_q.size() > 0);
      check_value("imem_req", {31'd0, bus0.imem_req}, {31'd0, exp_req});
      if (exp_req) check_value("imem_addr", bus0.imem_addr, m_fpc);
      check_value("fd_valid", {31'd0, bus0.fd_valid}, {31'd0, exp_val});
      check_value("fd_count", {29'd0, bus0.fd_count}, cur_rst ? m_q.size() : 32'd0);
      if (exp_val) begin
         pc = m_q[0];
         check_value("fd_pc", bus0.fd_pc, pc);
         check_value("fd_inst", bus0.fd_inst, rom(pc));
         check_value("fd_pcplus4", bus0.fd_pcplus4, pc + 32'd4);
      end else begin
         check_value("fd_inst_idle", bus0.fd_inst, 32'd0);
         if (!cur_rst) begin
            check_value("rst_fd_pc", bus0.fd_pc, 32'd0);
            check_value("rst_fd_pcplus4", bus0.fd_pcplus4, 32'd0);
         end
      end
   endtask

   // One clock: retire the edge in the model, drive next inputs, check at negedge.
   task automatic step(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
      @(posedge clock);
      model_edge();
      #1;
      cur_rst   = rst;
      cur_redir = redir;
      cur_rpc   = rpc;
      cur_ready = rdy;
      reset            = rst;
      bus0.redirect    = redir;
      bus0.redirect_pc = rpc;
      bus0.fd_ready    = rdy;
      @(negedge clock);
      compare_dut0();
   endtask

   initial begin
      logic [31:0] exp_pc;
      cur_rst = 1'b0; cur_redir = 1'b0; cur_rpc = 32'd0; cur_ready = 1'b0;
      reset = 1'b0;
      bus0.redirect = 1'b0; bus0.redirect_pc = 32'd0; bus0.fd_ready = 1'b0;
      bus1.redirect = 1'b0; bus1.redirect_pc = 32'd0; bus1.fd_ready = 1'b1;
      m_fpc = PC0; m_pend = 0; m_pend_pc = 32'd0;

      repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0);

      // Streaming from reset; second instance checks the PC wrap at the top of memory.
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b0, 32'd0, 1'b1);
         check_value("wrap_valid", {31'd0, bus1.fd_valid}, (k >= 3) ? 32'd1 : 32'd0);
         if (k >= 3) begin
            exp_pc = PC1 + 32'(4 * (k - 3));
            check_value("wrap_pc", bus1.fd_pc, exp_pc);
            check_value("wrap_pcplus4", bus1.fd_pcplus4, exp_pc + 32'd4);
            check_value("wrap_inst", bus1.fd_inst, rom(exp_pc));
         end
      end

      // Stall from a fresh reset, then release.
      repeat (2) step(1'b0, 1'b0, 32'd0, 1'b0);
      repeat (12) step(1'b1, 1'b0, 32'd0, 1'b0);
      repeat (10) step(1'b1, 1'b0, 32'd0, 1'b1);

      // Single redirect with an unaligned target, then a back-to-back pair.
      step(1'b1, 1'b1, 32'h0000_0103, 1'b1);
      repeat (6) step(1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
      step(1'b1, 1'b1, 32'h0000_0300, 1'b0);
      repeat (8) step(1'b1, 1'b0, 32'd0, 1'b1);

      // Reset together with a redirect: the target must be ignored.
      step(1'b0, 1'b1, 32'h0000_0500, 1'b1);
      repeat (6) step(1'b1, 1'b0, 32'd0, 1'b1);

      for (int n = 0; n < 1500; n++) begin
         logic        r_rst, r_redir, r_rdy;
         logic [31:0] r_pc;
         r_rst   = ($urandom_range(99) != 0);
         r_redir = ($urandom_range(19) == 0);
         r_rdy   = ($urandom_range(3) != 0);
         r_pc    = $urandom();
         if ($urandom_range(3) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
         step(r_rst, r_redir, r_pc, r_rdy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
